rr_arb_32: RTL and testbench
============================

RR_ARB_32 -- requirements
Module: rr_arb_32

Interface
REQ-001 SHALL have parameter N, default 32: number of requesters.
REQ-002 SHALL have parameter IDX_W, default 5: grant index width, equal to log2(N).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N bits: request vector; bit k high means requester k wants service.
REQ-006 SHALL have port gnt_valid, output, 1 bit: gnt_idx holds a valid grant.
REQ-007 SHALL have port gnt_ready, input, 1 bit: the downstream 5->32 decoder stage accepts the grant.
REQ-008 SHALL have port gnt_idx, output, IDX_W bits: binary index of the granted requester, which drives the downstream decoder input.
REQ-009 SHALL have port ptr_o, output, IDX_W bits: current priority pointer, for debug and verification.

Function
REQ-010 SHALL operate as a two-state FSM: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-011 SHALL, in IDLE with req != 0, select the first set bit searching circularly upward from ptr, and SHALL register that index into gnt_idx and enter GRANT on the next edge (latency 1 cycle).
REQ-012 SHALL, in IDLE with req == 0, stay in IDLE, leaving gnt_idx and ptr unchanged.
REQ-013 SHALL, in GRANT with gnt_ready=0, hold gnt_idx and ptr stable and ignore all req changes, including deassertion of the granted bit.
REQ-014 SHALL treat a grant as accepted in a cycle where gnt_valid=1 and gnt_ready=1.
REQ-015 SHALL, on acceptance, set ptr to (gnt_idx+1) mod N, wrapping 31 -> 0.
REQ-016 SHALL, on acceptance with req != 0 in the same cycle, issue the next grant back-to-back, searching circularly from (gnt_idx+1) mod N; gnt_valid stays 1 with the new index on the next edge.
REQ-017 SHALL, on acceptance with req == 0, return to IDLE.
REQ-018 SHALL, in a back-to-back search, re-grant the just-served requester only if it is the sole requester.
REQ-019 SHALL drive a gnt_idx that is always the index of a requester whose req bit was high in the cycle the grant was computed.
REQ-020 SHALL ignore gnt_ready while in IDLE.
REQ-021 SHALL guarantee no starvation: any requester holding req high is granted within N accepted grants.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, gnt_valid=0, gnt_idx=0 and ptr=0, independent of clk.
REQ-023 SHALL, when reset is asserted mid-GRANT, drop the pending grant immediately and never re-present it after reset.
REQ-024 SHALL evaluate the first grant after reset release at the first rising clk edge with rst_n=1.

Structure
REQ-025 SHALL take N, IDX_W and the FSM state encoding (IDLE=0, GRANT=1) from a shared package, arb_pkg.
REQ-026 SHALL implement the circular first-set search in one combinational sub-module, rr_pick (inputs req and start index; outputs found and index), instantiated once.
REQ-027 SHALL keep all outputs registered, with no combinational path from req or gnt_ready to any output.

Verification
REQ-028 Reset then req=32'h0000_0001 with gnt_ready=1 -> gnt_valid=1 and gnt_idx=0 after 1 cycle; ptr=1 after acceptance.
REQ-029 req=32'hFFFF_FFFF held with gnt_ready=1 for 33 cycles -> gnt_idx steps 0,1,...,31,0, with gnt_valid continuously 1 after the first grant.
REQ-030 req=32'h8000_0010 with ptr=5 and gnt_ready=1 -> grants 31 then 4; ptr wraps to 0 and then becomes 5.
REQ-031 Grant to index 7 with gnt_ready=0 for 4 cycles while req changes to 32'h0000_0100 -> gnt_idx stays 7 until gnt_ready=1, then 8.
REQ-032 rst_n pulsed low mid-GRANT (gnt_idx=12) -> gnt_valid=0, gnt_idx=0 and ptr=0 asynchronously; after release with req=32'h0000_1000 -> gnt_idx=12 with ptr starting at 0.
REQ-033 Sole requester 3 held high with gnt_ready=1 -> index 3 re-granted every cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared sizing and state encoding for the 32-way round-robin arbiter.
package arb_pkg;
  localparam int ARB_N     = 32;
  localparam int ARB_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arb_32_if.sv
// Request/grant bundle between the arbiter and its requesters and decoder stage.
interface rr_arb_32_if
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
);
  logic [N-1:0]     req;
  logic             gnt_valid;
  logic             gnt_ready;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_o;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_idx,
    output ptr_o
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_idx,
    input  ptr_o
  );
endinterface

// File: rtl/rr_pick.sv
// Circular first-set search: lowest-offset set bit of req at or above start, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  int k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/rr_arb_32.sv
// Round-robin arbiter: registered grant index with valid/ready handshake and
// a priority pointer that advances past each accepted grant.
module rr_arb_32
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_32_if.master bus
);
  arb_state_t       state;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  assign nxt_ptr = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  // Back-to-back search starts after the grant being accepted, so the served
  // requester is only picked again when nobody else is asking.
  assign start   = (state == GRANT) ? nxt_ptr : ptr;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_idx <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (bus.gnt_ready) begin
            ptr <= nxt_ptr;
            if (pick_found) gnt_idx <= pick_idx;
            else            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid = (state == GRANT);
  assign bus.gnt_idx   = gnt_idx;
  assign bus.ptr_o     = ptr;
endmodule

// File: tb/tb_rr_arb_32.sv
// Directed bench for rr_arb_32 with hand-computed grant/pointer sequences.
module tb_rr_arb_32;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rr_arb_32_if #(.N(32), .IDX_W(5)) bus ();

  rr_arb_32 #(.N(32), .IDX_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic v, input logic [4:0] idx, input logic [4:0] p);
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".idx"},   32'(bus.gnt_idx),   32'(idx));
    chk({tag, ".ptr"},   32'(bus.ptr_o),     32'(p));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.gnt_ready = 1'b0;
    #23;
    chk3("reset", 1'b0, 5'd0, 5'd0);
    step();
    rst_n = 1'b1;

    // single requester 0
    bus.req = 32'h0000_0001;
    bus.gnt_ready = 1'b1;
    step();
    chk3("r0.grant", 1'b1, 5'd0, 5'd0);
    bus.req = '0;
    step();
    chk3("r0.accept", 1'b0, 5'd0, 5'd1);

    // all requesting: full rotation from a fresh reset
    rst_n = 1'b0;
    #1;
    chk3("rst2", 1'b0, 5'd0, 5'd0);
    step();
    rst_n = 1'b1;
    bus.req = 32'hFFFF_FFFF;
    bus.gnt_ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step();
      chk("all.valid", 32'(bus.gnt_valid), 32'd1);
      chk("all.idx", 32'(bus.gnt_idx), 32'(i % 32));
    end
    chk("all.ptr", 32'(bus.ptr_o), 32'd0);
    bus.req = '0;
    step();
    chk3("all.end", 1'b0, 5'd0, 5'd1);

    // move pointer to 5, then wrap case 31 -> 4
    bus.req = 32'h0000_0010;
    step();
    chk3("p5.grant", 1'b1, 5'd4, 5'd1);
    bus.req = '0;
    step();
    chk3("p5.accept", 1'b0, 5'd4, 5'd5);
    bus.req = 32'h8000_0010;
    step();
    chk3("wrap.g31", 1'b1, 5'd31, 5'd5);
    step();
    chk3("wrap.g4", 1'b1, 5'd4, 5'd0);
    bus.req = '0;
    step();
    chk3("wrap.end", 1'b0, 5'd4, 5'd5);

    // stall with req changing underneath
    bus.req = 32'h0000_0080;
    bus.gnt_ready = 1'b0;
    step();
    chk3("stall.g7", 1'b1, 5'd7, 5'd5);
    bus.req = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk3("stall.hold", 1'b1, 5'd7, 5'd5);
    end
    bus.gnt_ready = 1'b1;
    step();
    chk3("stall.g8", 1'b1, 5'd8, 5'd8);
    bus.req = '0;
    step();
    chk3("stall.end", 1'b0, 5'd8, 5'd9);

    // async reset mid-grant
    bus.req = 32'h0000_1000;
    bus.gnt_ready = 1'b0;
    step();
    chk3("mid.g12", 1'b1, 5'd12, 5'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("mid.rst", 1'b0, 5'd0, 5'd0);
    step();
    chk3("mid.rsthold", 1'b0, 5'd0, 5'd0);
    rst_n = 1'b1;
    step();
    chk3("mid.regrant", 1'b1, 5'd12, 5'd0);
    bus.req = '0;
    bus.gnt_ready = 1'b1;
    step();
    chk3("mid.end", 1'b0, 5'd12, 5'd13);

    // sole requester re-granted every cycle
    bus.req = 32'h0000_0008;
    step();
    chk3("sole.g3", 1'b1, 5'd3, 5'd13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("sole.again", 1'b1, 5'd3, 5'd4);
    end

    // idle ignores ready and keeps index/pointer
    bus.req = '0;
    step();
    chk3("idle.enter", 1'b0, 5'd3, 5'd4);
    step();
    step();
    chk3("idle.hold", 1'b0, 5'd3, 5'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
